// File: rtl/pitch_pkg.sv
// Shared constants, sample/coefficient types and frame FSM states for the
// analysis and synthesis Hann windowers.
package pitch_pkg;

  localparam int unsigned WINDOW     = 4096;
  localparam int unsigned HOP        = 1024;
  localparam int unsigned RING_DEPTH = 5120;

  localparam int unsigned IDX_W  = 12;
  localparam int unsigned RING_W = 13;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WINDOW - 1);
  // Frame indices below this limit overlap the previous frame and are accumulated.
  localparam logic [IDX_W-1:0]  ADD_LIMIT = IDX_W'(WINDOW - HOP);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_DEPTH - 1);
  localparam logic [RING_W-1:0] RING_SIZE = RING_W'(RING_DEPTH);

  typedef logic signed [15:0] sample_t;
  typedef logic [15:0]        coef_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Fold an index in [0, 2*RING_DEPTH) back into the ring.
  function automatic logic [RING_W-1:0] ring_wrap(input logic [RING_W-1:0] a);
    return (a >= RING_SIZE) ? a - RING_SIZE : a;
  endfunction

  function automatic logic [RING_W-1:0] ring_inc(input logic [RING_W-1:0] a);
    return (a == RING_LAST) ? '0 : a + RING_W'(1);
  endfunction

endpackage

// File: rtl/hann_mac.sv
// Combinational Hann multiply plus optional saturating overlap-add.
module hann_mac
  import pitch_pkg::*;
(
  input  sample_t i_sample,
  input  coef_t   i_coef,
  input  sample_t i_acc,
  input  logic    i_add_en,
  output sample_t o_result
);

  logic signed [32:0] w_prod;
  sample_t            w_p;
  logic signed [16:0] w_sum;
  logic               w_unused_prod;

  // Coefficient is unsigned Q0.16, so zero-extend before the signed multiply.
  assign w_prod = $signed({1'b0, i_coef}) * i_sample;
  // |coef * sample| < 2^31, so the shifted product always fits in 16 bits.
  assign w_p           = w_prod[31:16];
  assign w_unused_prod = ^{w_prod[32], w_prod[15:0]};

  assign w_sum = {i_acc[15], i_acc} + {w_p[15], w_p};

  always_comb begin
    o_result = w_p;
    if (i_add_en) begin
      if (w_sum[16] != w_sum[15]) begin
        o_result = w_sum[16] ? 16'sh8000 : 16'sh7fff;
      end else begin
        o_result = w_sum[15:0];
      end
    end
  end

endmodule

// File: rtl/last_hannifier.sv
// Synthesis-side Hann windower: streams one IFFT frame through the Hann MAC and
// overlap-adds it into the output ring, pulsing done once the frame is committed.
module last_hannifier
  import pitch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [RING_W-1:0] window_start,
  input  logic              go_in,
  output logic [IDX_W-1:0]  in_buf_addr,
  input  logic [15:0]       in_buf_data,
  output logic [IDX_W-1:0]  hann_rom_addr,
  input  logic [15:0]       hann_rom_data,
  output logic [RING_W-1:0] ring_rd_addr,
  input  logic [15:0]       ring_rd_data,
  output logic [RING_W-1:0] ring_wr_addr,
  output logic [15:0]       ring_wr_data,
  output logic              ring_wren,
  output logic              busy,
  output logic              done
);

  state_e            r_state, w_state_d;
  logic [IDX_W-1:0]  r_idx, w_idx_d;
  logic [RING_W-1:0] r_rd_addr, w_rd_addr_d;
  logic              r_v1, w_v1_d;

  // Stage 2: read data is on the memory buses this cycle.
  logic              r_v2;
  logic              r_add2;
  logic [RING_W-1:0] r_addr2;

  logic              r_wren;
  logic [RING_W-1:0] r_wr_addr;
  sample_t           r_wr_data;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  sample_t           w_mac;

  hann_mac u_hann_mac (
    .i_sample (in_buf_data),
    .i_coef   (hann_rom_data),
    .i_acc    (ring_rd_data),
    .i_add_en (r_add2),
    .o_result (w_mac)
  );

  always_comb begin
    w_state_d   = r_state;
    w_idx_d     = r_idx;
    w_rd_addr_d = r_rd_addr;
    w_v1_d      = 1'b0;
    w_done_d    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (go_in) begin
          w_state_d   = RUN;
          w_idx_d     = '0;
          w_rd_addr_d = ring_wrap(window_start);
          w_v1_d      = 1'b1;
        end
      end
      RUN: begin
        if (r_idx == IDX_LAST) begin
          w_state_d = DRAIN;
        end else begin
          w_idx_d     = r_idx + IDX_W'(1);
          w_rd_addr_d = ring_inc(r_rd_addr);
          w_v1_d      = 1'b1;
        end
      end
      DRAIN: begin
        if (!r_v1 && !r_v2) begin
          w_state_d = DONE;
          w_done_d  = 1'b1;
        end
      end
      DONE: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
    w_busy_d = (w_state_d == RUN) || (w_state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_rd_addr <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_add2    <= 1'b0;
      r_addr2   <= '0;
      r_wren    <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_rd_addr <= w_rd_addr_d;
      r_v1      <= w_v1_d;
      r_v2      <= r_v1;
      r_add2    <= (r_idx < ADD_LIMIT);
      r_addr2   <= r_rd_addr;
      r_wren    <= r_v2;
      if (r_v2) begin
        r_wr_addr <= r_addr2;
        r_wr_data <= w_mac;
      end
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
    end
  end

  assign in_buf_addr   = r_idx;
  assign hann_rom_addr = r_idx;
  assign ring_rd_addr  = r_rd_addr;
  assign ring_wr_addr  = r_wr_addr;
  assign ring_wr_data  = r_wr_data;
  assign ring_wren     = r_wren;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
